// File: rtl/light_chaser_pkg.sv
// Shared constants and width-generic helpers for the LED chaser.
// Helpers work on a MAX_W-wide vector; callers zero-extend narrower patterns.
package light_chaser_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] pat_t;

  localparam pat_t DEFAULT_SEED = pat_t'(1);

  function automatic pat_t width_mask(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  // Zero and multi-hot both fail: exactly one bit must be set.
  function automatic logic is_onehot(input pat_t p);
    return (p != '0) && ((p & (p - pat_t'(1))) == '0);
  endfunction

  // Circular left shift by one within the low w bits.
  function automatic pat_t rotl1(input pat_t p, input int w);
    return ((p << 1) | (p >> (w - 1))) & width_mask(w);
  endfunction

endpackage

// File: rtl/light_chaser_prescaler.sv
// Step divider: pulses step_tick on the enabled cycle that completes STEP_DIV
// enabled cycles. Count freezes while enable is low.
module light_chaser_prescaler
  import light_chaser_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic step_tick
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_last;

  // With STEP_DIV=1 cnt is stuck at 0, so at_last is constant and tick == enable.
  assign at_last   = (cnt == LAST);
  assign step_tick = enable && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= at_last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/light_chaser.sv
// Single-LED chaser: a one-hot pattern rotates left once per step tick.
// A corrupted (non-one-hot) pattern is replaced by SEED on the next step.
module light_chaser
  import light_chaser_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               STEP_DIV = 1,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [WIDTH-1:0] led_pattern
);

  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
    $error("light_chaser: WIDTH out of range");
  end
  if (STEP_DIV < 1) begin : g_bad_div
    $error("light_chaser: STEP_DIV must be >= 1");
  end
  if (!is_onehot(pat_t'(SEED))) begin : g_bad_seed
    $error("light_chaser: SEED must be one-hot");
  end

  logic step_tick;
  pat_t cur_ext;
  pat_t rot_ext;

  light_chaser_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .step_tick (step_tick)
  );

  assign cur_ext = pat_t'(led_pattern);
  assign rot_ext = rotl1(cur_ext, WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_pattern <= SEED;
    end else if (step_tick) begin
      led_pattern <= is_onehot(cur_ext) ? WIDTH'(rot_ext) : SEED;
    end
  end

endmodule

// File: tb/tb_light_chaser.sv
// Bench for light_chaser: STEP_DIV=1 and STEP_DIV=4 instances against a
// position/edge-count model, directed scenarios plus a randomized phase.
module tb_light_chaser;

  logic       clk;
  logic       rst_n;
  logic       en1, en4;
  logic [7:0] led1, led4;

  int n_chk  = 0;
  int n_fail = 0;

  light_chaser #(.WIDTH(8), .STEP_DIV(1), .SEED(8'h01)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .led_pattern(led1));
  light_chaser #(.WIDTH(8), .STEP_DIV(4), .SEED(8'h01)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(en4), .led_pattern(led4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: lit LED index plus number of enabled edges since last step.
  int         pos1, pos4, edges4;
  logic       bad1;
  logic [7:0] badval1;
  logic       dep_pulse;
  logic [7:0] dep_val;

  always @(posedge clk or negedge rst_n or posedge dep_pulse) begin
    if (!rst_n) begin
      pos1 = 0; pos4 = 0; edges4 = 0; bad1 = 1'b0; badval1 = 8'h00;
    end else if (dep_pulse) begin
      bad1 = 1'b1; badval1 = dep_val;
    end else begin
      if (en1) begin
        if (bad1) begin pos1 = 0; bad1 = 1'b0; end
        else pos1 = (pos1 + 1) % 8;
      end
      if (en4) begin
        edges4 = edges4 + 1;
        if (edges4 == 4) begin edges4 = 0; pos4 = (pos4 + 1) % 8; end
      end
    end
  end

  function automatic logic [7:0] exp1();
    return bad1 ? badval1 : 8'(1 << pos1);
  endfunction
  function automatic logic [7:0] exp4();
    return 8'(1 << pos4);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model1", led1, exp1());
    chk("model4", led4, exp4());
    if (!bad1) chk("onehot1", {7'b0, $onehot(led1)}, 8'h01);
    chk("onehot4", {7'b0, $onehot(led4)}, 8'h01);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic deposit(input logic [7:0] v);
    dep_val = v;
    dut1.led_pattern = v;
    dep_pulse = 1'b1;
    #1 dep_pulse = 1'b0;
  endtask

  logic [7:0] seq2 [8];

  initial begin
    seq2 = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    rst_n = 1'b1; en1 = 1'b0; en4 = 1'b0; dep_pulse = 1'b0; dep_val = 8'h00;

    // 1: async reset visible before any clock edge
    #2 rst_n = 1'b0;
    #1 chk("rst_async1", led1, 8'h01);
    chk("rst_async4", led4, 8'h01);
    cyc(2);
    chk("rst_held1", led1, 8'h01);

    // 2: rotate eight times, wrapping back to bit 0
    rst_n = 1'b1; en1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("rotate", led1, seq2[i]);
    end

    // 3: hold at 08, then resume
    cyc(3);
    chk("pre_hold", led1, 8'h08);
    en1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("hold", led1, 8'h08);
    end
    en1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("resume", led1, seq2[i + 3]);
    end

    // 4: reset mid-rotation at 20, release with enable high
    cyc(6);
    chk("at_20", led1, 8'h20);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid", led1, 8'h01);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst", led1, 8'h02);
    en1 = 1'b0;

    // 5: divide-by-4 instance
    en4 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      chk("div4", led4, 8'(1 << (k / 4)));
    end
    cyc(2);
    en4 = 1'b0;
    cyc(3);
    chk("div4_hold", led4, 8'h10);
    en4 = 1'b1;
    cyc(1);
    chk("div4_pre", led4, 8'h10);
    cyc(1);
    chk("div4_step", led4, 8'h20);
    en4 = 1'b0;

    // 6: integrity guard reloads SEED from a corrupted pattern
    deposit(8'h00);
    cyc(1);
    chk("dep_zero", led1, 8'h00);
    en1 = 1'b1;
    cyc(1);
    chk("guard_zero", led1, 8'h01);
    cyc(1);
    chk("guard_next", led1, 8'h02);
    en1 = 1'b0;
    deposit(8'h03);
    cyc(1);
    chk("dep_multi", led1, 8'h03);
    en1 = 1'b1;
    cyc(1);
    chk("guard_multi", led1, 8'h01);
    cyc(1);
    chk("guard_after", led1, 8'h02);

    // Randomized phase: enables and occasional async reset pulses
    for (int i = 0; i < 400; i++) begin
      en1 = 1'($urandom_range(0, 1));
      en4 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk("rnd_rst", led1, 8'h01);
        #1 rst_n = 1'b1;
      end
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
